hello_scroll_ctrl: RTL and testbench
====================================

Name: hello_scroll_ctrl

Overview:
Sequencing controller for the 8-digit HELLO scroller on HEX7..HEX0. It owns the scroll prescaler and the 3-bit character offset, and supports run, pause, stop, single-step, direction and speed. It outputs the eight 3-bit character codes that feed the existing per-digit letter decoders. The scroll datapath becomes a pure consumer of this block's outputs.

Parameters:
BASE_DIV, 16777216, scroll period in Clock cycles at Speed=0; must be a power of two and at least 8 (bench uses 16).
CNT_W, 24, prescaler width; must satisfy 2^CNT_W >= BASE_DIV.

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-high; returns the block to IDLE.
Start  input  1  level button; its rising edge starts or resumes scrolling.
Stop   input  1  level button; its rising edge pauses (from RUN) or clears (from PAUSE).
Step   input  1  level button; its rising edge advances one position while not running.
Dir    input  1  0 = offset increments (text moves left); 1 = offset decrements.
Speed  input  2  period = BASE_DIV >> Speed cycles.
Offset output 3  current character index shown on HEX7.
Chars  output 24 [23:21]=HEX7 code=Offset, [20:18]=Offset+1, ... [2:0]=Offset+7, all mod 8.
Tick   output 1  one-cycle pulse, asserted in the cycle after every offset advance.
Running output 1 high while in state RUN.

Behaviour:
- Reset: state=IDLE, Offset=0, prescaler=0, Tick=0, Running=0, button history regs=0. Chars therefore = 0,1,...,7.
- Edge detect: rise = In & ~In_q, where In_q is the registered previous level. An action takes effect on the first clock edge that samples the input high. Holding a button produces one action only.
- Priority when edges coincide: Stop > Start > Step.
- TC = (BASE_DIV >> Speed) - 1, computed at CNT_W bits.
- States:
  - IDLE: prescaler held at 0.
    - Start -> RUN.
    - Step -> advance.
    - Stop -> no effect.
  - RUN: each cycle, if prescaler >= TC then advance and prescaler<=0; otherwise prescaler+1.
    - Stop -> PAUSE; prescaler holds its value.
    - Start and Step are ignored.
  - PAUSE: prescaler and Offset frozen.
    - Start -> RUN; counting resumes from the held value.
    - Step -> advance; prescaler unchanged.
    - Stop -> IDLE; Offset<=0, prescaler<=0.
- Advance: Offset <= Offset+1 if Dir=0, else Offset-1. Uses modulo-8 wrap (7->0, 0->7). Tick<=1 on the same edge. Dir is sampled on that edge.
- A Stop edge arriving on the same edge as a terminal count wins. The state goes to PAUSE, no advance happens and Tick stays 0.
- Speed change mid-count: the >= compare ensures a prescaler already past the new TC advances on the next edge. The prescaler never runs to wraparound.
- Tick is registered and high for exactly one cycle per advance. Consecutive advances (TC=0 is impossible since BASE_DIV>=8) are at least 2 cycles apart at Speed=3 for BASE_DIV=16.
- Chars is combinational from Offset; each of the 8 adders is a 3-bit modulo add.
- Reset asserted mid-RUN clears everything immediately, regardless of Clock.

Decomposition:
- Package hello_pkg holds:
  - the state enum {IDLE, RUN, PAUSE};
  - character code constants CH_H=0, CH_E=1, CH_L=2/3, CH_O=4, CH_BLANK=5..7;
  - NUM_DIGITS=8 and CHAR_W=3, shared with the letter decoder.
- One sub-module, btn_rise, is natural. It holds the edge-detect register with async active-high reset and is instantiated three times.

Test Plan:
1. Reset, then Start rises, BASE_DIV=16, Speed=0, Dir=0 -> Running=1 next edge; Tick every 16 cycles; Offset 0,1,...,7,0; Chars=0x053977 when Offset=0.
2. Speed=3 while running with prescaler=10 -> advance on the next edge; thereafter Tick every 2 cycles.
3. Stop during RUN, hold 20 cycles, then Start -> Offset frozen during PAUSE; first Tick after resume arrives at TC minus held prescaler plus 1 cycles.
4. From IDLE, Dir=1, three Step pulses -> Offset 7,6,5 with one Tick each; Running stays 0; Step held high for 10 cycles counts once.
5. Stop and Start rising on the same edge in RUN at terminal count -> PAUSE, no advance, Tick=0; second Stop -> IDLE with Offset=0.
6. Reset asserted asynchronously mid-RUN between clock edges -> Offset=0, Running=0, Tick=0 immediately; no action on the first edge after release unless a button edge is present.

Source files
------------

// File: rtl/hello_scroll_ctrl_pkg.sv
// Shared types and constants for the HELLO scroller controller and its letter decoders.
package hello_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 8;
    localparam int CHAR_W     = 3;

    localparam logic [CHAR_W-1:0] CH_H     = 3'd0;
    localparam logic [CHAR_W-1:0] CH_E     = 3'd1;
    localparam logic [CHAR_W-1:0] CH_L     = 3'd2;
    localparam logic [CHAR_W-1:0] CH_L2    = 3'd3;
    localparam logic [CHAR_W-1:0] CH_O     = 3'd4;
    localparam logic [CHAR_W-1:0] CH_BLANK = 3'd5;

    localparam logic [CHAR_W-1:0] OFF_ONE  = 3'd1;

    // Modulo-8 wrap falls out of the 3-bit arithmetic.
    function automatic logic [CHAR_W-1:0] step_offset(input logic [CHAR_W-1:0] off,
                                                      input logic dir);
        return dir ? (off - OFF_ONE) : (off + OFF_ONE);
    endfunction

endpackage

// File: rtl/hello_scroll_ctrl_if.sv
// Button/control inputs and character outputs of the scroll controller.
interface hello_scroll_ctrl_if;
    import hello_pkg::*;

    logic                         Start;
    logic                         Stop;
    logic                         Step;
    logic                         Dir;
    logic [1:0]                   Speed;
    logic [CHAR_W-1:0]            Offset;
    logic [NUM_DIGITS*CHAR_W-1:0] Chars;
    logic                         Tick;
    logic                         Running;

    modport master (
        output Start, Stop, Step, Dir, Speed,
        input  Offset, Chars, Tick, Running
    );

    modport slave (
        input  Start, Stop, Step, Dir, Speed,
        output Offset, Chars, Tick, Running
    );

endinterface

// File: rtl/hello_scroll_ctrl_btn_rise.sv
// Rising-edge detector for a level button; one pulse per press regardless of hold time.
module btn_rise (
    input  logic Clock,
    input  logic Reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) level_q <= 1'b0;
        else       level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Scroll sequencing controller: prescaler, character offset and run/pause/step FSM.
//
// state | meaning
// IDLE  | stopped, prescaler held at 0, Step advances
// RUN   | prescaler counting, advance on terminal count
// PAUSE | prescaler and offset frozen, Step advances, Stop clears
module hello_scroll_ctrl
    import hello_pkg::*;
#(
    parameter int BASE_DIV = 16777216,
    parameter int CNT_W    = 24
) (
    input  logic                Clock,
    input  logic                Reset,
    hello_scroll_ctrl_if.slave  bus
);

    // BASE_DIV is a power of two, so (BASE_DIV >> s) - 1 == (BASE_DIV - 1) >> s,
    // which keeps the whole computation inside CNT_W bits.
    localparam logic [CNT_W-1:0] TC_BASE = CNT_W'(BASE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic [CNT_W-1:0]             tc;
    logic [CHAR_W-1:0]            offset, offset_nxt;
    logic                         tick_q, tick_nxt;
    logic                         start_rise, stop_rise, step_rise;
    logic [NUM_DIGITS*CHAR_W-1:0] chars;

    btn_rise u_start (.Clock(Clock), .Reset(Reset), .level(bus.Start), .rise(start_rise));
    btn_rise u_stop  (.Clock(Clock), .Reset(Reset), .level(bus.Stop),  .rise(stop_rise));
    btn_rise u_step  (.Clock(Clock), .Reset(Reset), .level(bus.Step),  .rise(step_rise));

    assign tc = TC_BASE >> bus.Speed;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            offset <= '0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            offset <= offset_nxt;
            tick_q <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        offset_nxt = offset;
        tick_nxt   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!stop_rise) begin
                    if (start_rise) begin
                        state_nxt = RUN;
                    end else if (step_rise) begin
                        offset_nxt = step_offset(offset, bus.Dir);
                        tick_nxt   = 1'b1;
                    end
                end
            end
            RUN: begin
                // Stop beats a coincident terminal count: no advance on that edge.
                if (stop_rise) begin
                    state_nxt = PAUSE;
                end else if (cnt >= tc) begin
                    cnt_nxt    = '0;
                    offset_nxt = step_offset(offset, bus.Dir);
                    tick_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PAUSE: begin
                if (stop_rise) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    offset_nxt = '0;
                end else if (start_rise) begin
                    state_nxt = RUN;
                end else if (step_rise) begin
                    offset_nxt = step_offset(offset, bus.Dir);
                    tick_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                offset_nxt = '0;
            end
        endcase
    end

    always_comb begin
        chars = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            chars[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] = offset + CHAR_W'(i);
        end
    end

    assign bus.Offset  = offset;
    assign bus.Chars   = chars;
    assign bus.Tick    = tick_q;
    assign bus.Running = (state == RUN);

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed self-checking bench for hello_scroll_ctrl with BASE_DIV=16.
module tb_hello_scroll_ctrl;

    logic Clock;
    logic Reset;
    int   total;
    int   bad;

    hello_scroll_ctrl_if bus();

    hello_scroll_ctrl #(.BASE_DIV(16), .CNT_W(8)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!bus.Tick && n < limit);
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        bus.Step  = 1'b0;
        bus.Dir   = 1'b0;
        bus.Speed = 2'd0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        total++; if (bus.Offset !== 3'd0) begin bad++; $display("FAIL reset_offset: got %0d expected 0", bus.Offset); end
        total++; if (bus.Running !== 1'b0) begin bad++; $display("FAIL reset_running: got %0b expected 0", bus.Running); end
        total++; if (bus.Tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0b expected 0", bus.Tick); end
        total++; if (bus.Chars !== 24'h053977) begin bad++; $display("FAIL reset_chars: got %h expected 053977", bus.Chars); end
    endtask

    task automatic test_run();
        int n;
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        total++; if (bus.Running !== 1'b1) begin bad++; $display("FAIL run_running: got %0b expected 1", bus.Running); end
        for (int k = 1; k <= 8; k++) begin
            wait_tick(40, n);
            total++; if (n != 16) begin bad++; $display("FAIL run_gap%0d: got %0d cycles expected 16", k, n); end
            total++; if (bus.Offset !== 3'(k % 8)) begin bad++; $display("FAIL run_offset%0d: got %0d expected %0d", k, bus.Offset, k % 8); end
            if (k == 1) begin
                total++; if (bus.Chars !== 24'h29CBB8) begin bad++; $display("FAIL run_chars1: got %h expected 29cbb8", bus.Chars); end
            end
        end
        total++; if (bus.Chars !== 24'h053977) begin bad++; $display("FAIL run_chars0: got %h expected 053977", bus.Chars); end
    endtask

    task automatic test_speed();
        int n;
        repeat (10) @(negedge Clock);
        total++; if (bus.Tick !== 1'b0 || bus.Offset !== 3'd0) begin bad++; $display("FAIL speed_pre: got tick=%0b off=%0d expected tick=0 off=0", bus.Tick, bus.Offset); end
        bus.Speed = 2'd3;
        wait_tick(40, n);
        total++; if (n != 1) begin bad++; $display("FAIL speed_first: got %0d cycles expected 1", n); end
        total++; if (bus.Offset !== 3'd1) begin bad++; $display("FAIL speed_off1: got %0d expected 1", bus.Offset); end
        for (int k = 0; k < 2; k++) begin
            wait_tick(40, n);
            total++; if (n != 2) begin bad++; $display("FAIL speed_gap%0d: got %0d cycles expected 2", k, n); end
        end
        total++; if (bus.Offset !== 3'd3) begin bad++; $display("FAIL speed_off3: got %0d expected 3", bus.Offset); end
    endtask

    task automatic test_pause();
        int  n;
        logic tick_seen;
        logic off_moved;
        bus.Speed = 2'd0;
        repeat (5) @(negedge Clock);
        bus.Stop = 1'b1;
        @(negedge Clock);
        bus.Stop = 1'b0;
        total++; if (bus.Running !== 1'b0) begin bad++; $display("FAIL pause_running: got %0b expected 0", bus.Running); end
        tick_seen = 1'b0;
        off_moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (bus.Tick) tick_seen = 1'b1;
            if (bus.Offset !== 3'd3) off_moved = 1'b1;
        end
        total++; if (tick_seen !== 1'b0) begin bad++; $display("FAIL pause_tick: got 1 expected 0"); end
        total++; if (off_moved !== 1'b0) begin bad++; $display("FAIL pause_offset: got %0d expected 3", bus.Offset); end
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        total++; if (bus.Running !== 1'b1) begin bad++; $display("FAIL resume_running: got %0b expected 1", bus.Running); end
        wait_tick(40, n);
        total++; if (n != 11) begin bad++; $display("FAIL resume_gap: got %0d cycles expected 11", n); end
        total++; if (bus.Offset !== 3'd4) begin bad++; $display("FAIL resume_offset: got %0d expected 4", bus.Offset); end
    endtask

    task automatic test_step();
        int ticks;
        logic [2:0] exp_off [3];
        exp_off[0] = 3'd7; exp_off[1] = 3'd6; exp_off[2] = 3'd5;
        bus.Stop = 1'b1;  @(negedge Clock);
        bus.Stop = 1'b0;  @(negedge Clock);
        bus.Stop = 1'b1;  @(negedge Clock);
        bus.Stop = 1'b0;
        total++; if (bus.Offset !== 3'd0 || bus.Running !== 1'b0) begin bad++; $display("FAIL to_idle: got off=%0d run=%0b expected off=0 run=0", bus.Offset, bus.Running); end
        bus.Dir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.Step = 1'b1;
            @(negedge Clock);
            total++; if (bus.Tick !== 1'b1) begin bad++; $display("FAIL step_tick%0d: got %0b expected 1", k, bus.Tick); end
            total++; if (bus.Offset !== exp_off[k]) begin bad++; $display("FAIL step_offset%0d: got %0d expected %0d", k, bus.Offset, exp_off[k]); end
            total++; if (bus.Running !== 1'b0) begin bad++; $display("FAIL step_running%0d: got %0b expected 0", k, bus.Running); end
            bus.Step = 1'b0;
            @(negedge Clock);
            total++; if (bus.Tick !== 1'b0) begin bad++; $display("FAIL step_tick_low%0d: got %0b expected 0", k, bus.Tick); end
        end
        ticks = 0;
        bus.Step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (bus.Tick) ticks++;
        end
        bus.Step = 1'b0;
        bus.Dir  = 1'b0;
        total++; if (ticks != 1) begin bad++; $display("FAIL step_hold_ticks: got %0d expected 1", ticks); end
        total++; if (bus.Offset !== 3'd4) begin bad++; $display("FAIL step_hold_offset: got %0d expected 4", bus.Offset); end
    endtask

    task automatic test_stop_at_tc();
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (15) @(negedge Clock);
        total++; if (bus.Tick !== 1'b0 || bus.Offset !== 3'd4) begin bad++; $display("FAIL tc_pre: got tick=%0b off=%0d expected tick=0 off=4", bus.Tick, bus.Offset); end
        bus.Stop  = 1'b1;
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Stop  = 1'b0;
        bus.Start = 1'b0;
        total++; if (bus.Running !== 1'b0) begin bad++; $display("FAIL tc_running: got %0b expected 0", bus.Running); end
        total++; if (bus.Tick !== 1'b0) begin bad++; $display("FAIL tc_tick: got %0b expected 0", bus.Tick); end
        total++; if (bus.Offset !== 3'd4) begin bad++; $display("FAIL tc_offset: got %0d expected 4", bus.Offset); end
        @(negedge Clock);
        bus.Stop = 1'b1;
        @(negedge Clock);
        bus.Stop = 1'b0;
        total++; if (bus.Offset !== 3'd0 || bus.Running !== 1'b0) begin bad++; $display("FAIL tc_clear: got off=%0d run=%0b expected off=0 run=0", bus.Offset, bus.Running); end
    endtask

    task automatic test_async_reset();
        int n;
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        wait_tick(40, n);
        total++; if (n != 16 || bus.Offset !== 3'd1) begin bad++; $display("FAIL ar_pre: got gap=%0d off=%0d expected gap=16 off=1", n, bus.Offset); end
        #2 Reset = 1'b1;
        #1;
        total++; if (bus.Offset !== 3'd0) begin bad++; $display("FAIL ar_offset: got %0d expected 0", bus.Offset); end
        total++; if (bus.Running !== 1'b0) begin bad++; $display("FAIL ar_running: got %0b expected 0", bus.Running); end
        total++; if (bus.Tick !== 1'b0) begin bad++; $display("FAIL ar_tick: got %0b expected 0", bus.Tick); end
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        total++; if (bus.Running !== 1'b0 || bus.Offset !== 3'd0 || bus.Tick !== 1'b0) begin bad++; $display("FAIL ar_release: got run=%0b off=%0d tick=%0b expected 0 0 0", bus.Running, bus.Offset, bus.Tick); end
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        wait_tick(40, n);
        total++; if (n != 16) begin bad++; $display("FAIL ar_restart_gap: got %0d cycles expected 16", n); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        do_reset();
        test_reset();
        test_run();
        test_speed();
        test_pause();
        test_step();
        test_stop_at_tc();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
